// File: rtl/cache_arb_pkg.sv
// Shared encodings for the cache memory arbiter: FSM states, grant IDs,
// default line length and the tie-break helper.
package cache_arb_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_I_CMD   = 3'd1;
    localparam logic [2:0] ST_I_DATA  = 3'd2;
    localparam logic [2:0] ST_D_RCMD  = 3'd3;
    localparam logic [2:0] ST_D_RDATA = 3'd4;
    localparam logic [2:0] ST_D_WR    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        I_CMD   = ST_I_CMD,
        I_DATA  = ST_I_DATA,
        D_RCMD  = ST_D_RCMD,
        D_RDATA = ST_D_RDATA,
        D_WR    = ST_D_WR
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int unsigned LINE_BEATS = 8;

    // Winner of an arbitration round; a tie goes to whoever was not served last
    // unless the icache has fixed priority.
    function automatic logic pick_grant(input logic i_req, input logic d_req,
                                        input logic last_grant, input logic fixed_prio);
        logic g;
        g = GNT_D;
        if (i_req && d_req)
            g = (fixed_prio || (last_grant == GNT_D)) ? GNT_I : GNT_D;
        else if (i_req)
            g = GNT_I;
        return g;
    endfunction

endpackage

// File: rtl/cache_memory_arbiter_beat_counter.sv
// Beat counter shared by the read-data and write paths: latches the burst
// length on grant and flags the beat that completes the burst.
module cache_arb_beat_counter
    import cache_arb_pkg::*;
#(
    parameter int unsigned BC_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [BC_W-1:0] len,
    input  logic            clear,
    input  logic            inc,
    output logic [BC_W-1:0] burst_len,
    output logic            last_c
);

    logic [BC_W-1:0] count;

    // A zero burstcount still moves one beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            burst_len <= BC_W'(LINE_BEATS);
        end else begin
            if (load)
                burst_len <= (len == '0) ? BC_W'(1) : len;
            if (clear)
                count <= '0;
            else if (inc)
                count <= count + BC_W'(1);
        end
    end

    assign last_c = inc && ((count + BC_W'(1)) == burst_len);

endmodule

// File: rtl/cache_memory_arbiter.sv
// Shares one Avalon-MM burst master between the icache fill engine and the
// dcache fill/writeback engine. CACHE_ARB_IFETCH_PRIO_EN selects fixed icache priority.
module cache_memory_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BC_W   = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    input  logic [BC_W-1:0]   i_burstcount,
    output logic              i_waitrequest,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_readdatavalid,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BC_W-1:0]   d_burstcount,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_readdatavalid,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BC_W-1:0]   m_burstcount,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
);

    arb_state_e      state;
    logic            last_grant;
    logic            i_req, d_req, gnt;
    logic            in_data, decide, grant_ok, cmd_accept;
    logic            beat_inc, beat_last, clr_cnt;
    logic [BC_W-1:0] win_bc, burst_len;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_IFETCH_PRIO_EN
    assign gnt = pick_grant(i_req, d_req, last_grant, 1'b1);
`else
    assign gnt = pick_grant(i_req, d_req, last_grant, 1'b0);
`endif

    // The last read beat doubles as an arbitration point so bursts go back to back.
    assign in_data    = (state == I_DATA) || (state == D_RDATA);
    assign decide     = (state == IDLE) || (in_data && beat_last);
    assign grant_ok   = decide && (i_req || d_req);
    assign cmd_accept = ((state == I_CMD)  && i_read && !m_waitrequest) ||
                        ((state == D_RCMD) && d_read && !m_waitrequest);
    assign beat_inc   = (in_data && m_readdatavalid) ||
                        ((state == D_WR) && d_write && !m_waitrequest);
    assign clr_cnt    = grant_ok || cmd_accept;
    assign win_bc     = (gnt == GNT_I) ? i_burstcount : d_burstcount;

    cache_arb_beat_counter #(
        .BC_W (BC_W)
    ) u_beat_cnt (
        .clock     (clock),
        .reset     (reset),
        .load      (grant_ok),
        .len       (win_bc),
        .clear     (clr_cnt),
        .inc       (beat_inc),
        .burst_len (burst_len),
        .last_c    (beat_last)
    );

    // A dcache write wins over a simultaneous dcache read; the read stays pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GNT_D;
        end else if (grant_ok) begin
            last_grant <= gnt;
            if (gnt == GNT_I)
                state <= I_CMD;
            else if (d_write)
                state <= D_WR;
            else
                state <= D_RCMD;
        end else begin
            case (state)
                I_CMD:   if (cmd_accept) state <= I_DATA;
                D_RCMD:  if (cmd_accept) state <= D_RDATA;
                I_DATA,
                D_RDATA,
                D_WR:    if (beat_last)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_address       = '0;
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_writedata     = '0;
        m_burstcount    = '0;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdatavalid = 1'b0;
        d_readdatavalid = 1'b0;
        i_readdata      = '0;
        d_readdata      = '0;
        case (state)
            I_CMD: begin
                m_address     = i_address;
                m_read        = i_read;
                m_burstcount  = burst_len;
                i_waitrequest = m_waitrequest;
            end
            D_RCMD: begin
                m_address     = d_address;
                m_read        = d_read;
                m_burstcount  = burst_len;
                d_waitrequest = m_waitrequest;
            end
            D_WR: begin
                m_address     = d_address;
                m_write       = d_write;
                m_writedata   = d_writedata;
                m_burstcount  = burst_len;
                d_waitrequest = m_waitrequest;
            end
            I_DATA: begin
                i_readdatavalid = m_readdatavalid;
                i_readdata      = m_readdatavalid ? m_readdata : '0;
            end
            D_RDATA: begin
                d_readdatavalid = m_readdatavalid;
                d_readdata      = m_readdatavalid ? m_readdata : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_memory_arbiter.sv
// Directed and randomized bench for cache_memory_arbiter against a
// transaction-level model of grants and burst routing.
`timescale 1ns/1ps
module tb_cache_memory_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BC_W   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic [BC_W-1:0]   i_burstcount;
    logic              i_waitrequest;
    logic [DATA_W-1:0] i_readdata;
    logic              i_readdatavalid;
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_writedata;
    logic [BC_W-1:0]   d_burstcount;
    logic              d_waitrequest;
    logic [DATA_W-1:0] d_readdata;
    logic              d_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BC_W-1:0]   m_burstcount;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;

    always #5 clock = ~clock;

    cache_memory_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .i_address       (i_address),
        .i_read          (i_read),
        .i_burstcount    (i_burstcount),
        .i_waitrequest   (i_waitrequest),
        .i_readdata      (i_readdata),
        .i_readdatavalid (i_readdatavalid),
        .d_address       (d_address),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_writedata     (d_writedata),
        .d_burstcount    (d_burstcount),
        .d_waitrequest   (d_waitrequest),
        .d_readdata      (d_readdata),
        .d_readdatavalid (d_readdatavalid),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_burstcount    (m_burstcount),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .m_waitrequest   (m_waitrequest)
    );

    int compared   = 0;
    int mismatched = 0;
    bit grant_log[$];   // 0 = icache, 1 = dcache, in grant order since reset

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: single requester wins; a tie goes to the side not served last.
    function automatic bit model_pick(input bit ireq, input bit dreq);
        bit prev_d = (grant_log.size() == 0) ? 1'b1 : grant_log[$];
        bit g;
        if (ireq && dreq) begin
`ifdef CACHE_ARB_IFETCH_PRIO_EN
            g = 1'b0;
`else
            g = prev_d ? 1'b0 : 1'b1;
`endif
        end else begin
            g = dreq;
        end
        grant_log.push_back(g);
        return g;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_read"},  64'(m_read), 64'(0));
        check({tag, "_m_write"}, 64'(m_write), 64'(0));
        check({tag, "_i_wait"},  64'(i_waitrequest), 64'(1));
        check({tag, "_d_wait"},  64'(d_waitrequest), 64'(1));
        check({tag, "_i_rdv"},   64'(i_readdatavalid), 64'(0));
        check({tag, "_d_rdv"},   64'(d_readdatavalid), 64'(0));
    endtask

    // Entered with the owner's read command on the bus; returns after the last beat edge.
    task automatic serve_read(input bit is_d, input int bc, input bit rereq, input int stall_pct);
        int beats = (bc == 0) ? 1 : bc;
        int got = 0;
        bit accepted = 1'b0;
        bit gap;
        logic [ADDR_W-1:0] a = is_d ? d_address : i_address;
        for (int n = 0; n < 32 && !accepted; n++) begin
            m_waitrequest = (n < 31) && (int'($urandom_range(99)) < stall_pct);
            look();
            check("cmd_m_read", 64'(m_read), 64'(1));
            check("cmd_m_write", 64'(m_write), 64'(0));
            check("cmd_addr", 64'(m_address), 64'(a));
            check("cmd_bc", 64'(m_burstcount), 64'(beats));
            check("cmd_owner_wait", 64'(is_d ? d_waitrequest : i_waitrequest), 64'(m_waitrequest));
            check("cmd_other_wait", 64'(is_d ? i_waitrequest : d_waitrequest), 64'(1));
            accepted = !m_waitrequest;
            cyc();
        end
        m_waitrequest = 1'b0;
        if (is_d) d_read = 1'b0; else i_read = 1'b0;
        for (int n = 0; n < 64 && got < beats; n++) begin
            gap = (n < 48) && (int'($urandom_range(99)) < stall_pct);
            m_readdatavalid = !gap;
            m_readdata = {$urandom, $urandom};
            if (!gap && got == beats - 1 && rereq) begin
                if (is_d) d_read = 1'b1; else i_read = 1'b1;
            end
            look();
            check("rd_owner_rdv", 64'(is_d ? d_readdatavalid : i_readdatavalid), 64'(!gap));
            if (!gap)
                check("rd_owner_data", is_d ? d_readdata : i_readdata, m_readdata);
            check("rd_other_rdv", 64'(is_d ? i_readdatavalid : d_readdatavalid), 64'(0));
            check("rd_m_read_low", 64'(m_read), 64'(0));
            if (!gap) got++;
            cyc();
        end
        m_readdatavalid = 1'b0;
        check("rd_beats_delivered", 64'(got), 64'(beats));
    endtask

    // Entered in the write state; returns in IDLE after the last accepted beat.
    task automatic serve_write(input int bc, input int stall_pct, input logic [15:0] stall_once);
        int beats = (bc == 0) ? 1 : bc;
        int acc = 0;
        bit stalled = 1'b0;
        bit accepted;
        logic [63:0] sent[$];
        logic [63:0] seen[$];
        d_writedata = {$urandom, $urandom};
        for (int n = 0; n < 64 && acc < beats; n++) begin
            m_waitrequest = (n < 48) && ((stall_once[acc] && !stalled) ||
                            (int'($urandom_range(99)) < stall_pct));
            if (m_waitrequest) stalled = 1'b1;
            look();
            check("wr_m_write", 64'(m_write), 64'(1));
            check("wr_m_read", 64'(m_read), 64'(0));
            check("wr_addr", 64'(m_address), 64'(d_address));
            check("wr_bc", 64'(m_burstcount), 64'(beats));
            check("wr_d_wait", 64'(d_waitrequest), 64'(m_waitrequest));
            check("wr_i_wait", 64'(i_waitrequest), 64'(1));
            accepted = !m_waitrequest;
            if (accepted) begin
                sent.push_back(d_writedata);
                seen.push_back(m_writedata);
                acc++;
                stalled = 1'b0;
            end
            cyc();
            if (accepted) begin
                if (acc == beats) d_write = 1'b0;
                else d_writedata = {$urandom, $urandom};
            end
        end
        m_waitrequest = 1'b0;
        check("wr_beats_accepted", 64'(acc), 64'(beats));
        for (int k = 0; k < sent.size() && k < seen.size(); k++)
            check("wr_data_order", seen[k], sent[k]);
        look();
        check("wr_done_m_write", 64'(m_write), 64'(0));
        check("wr_done_m_read", 64'(m_read), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        grant_log.delete();
        cyc();
    endtask

    initial begin
        bit g;
        bit was_write;
        bit in_idle;
        int kind;

        reset = 1'b1;
        i_address = '0; i_read = 1'b0; i_burstcount = '0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_burstcount = '0;
        m_readdata = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
        cyc();
        cyc();
        look();
        check_reset_outputs("reset");
        reset = 1'b0;
        grant_log.delete();
        cyc();

        // icache-only 8-beat line fill
        i_address = 32'h0000_1040; i_burstcount = 4'd8; i_read = 1'b1;
        look();
        check("t1_grant_latency", 64'(m_read), 64'(0));
        cyc();
        g = model_pick(1'b1, 1'b0);
        serve_read(g, 8, 1'b0, 0);
        m_readdatavalid = 1'b1;
        look();
        check("t1_idle_i_rdv", 64'(i_readdatavalid), 64'(0));
        check("t1_idle_d_rdv", 64'(d_readdatavalid), 64'(0));
        check("t1_idle_i_wait", 64'(i_waitrequest), 64'(1));
        cyc();
        m_readdatavalid = 1'b0;

        // simultaneous requests, re-raised at each decision point
        do_reset();
        i_address = 32'h0000_2000; d_address = 32'h0000_3000;
        i_burstcount = 4'd2; d_burstcount = 4'd2;
        i_read = 1'b1; d_read = 1'b1;
        cyc();
        for (int r = 0; r < 3; r++) begin
            g = model_pick(i_read, d_read);
            serve_read(g, 2, r < 2, 0);
        end
        g = model_pick(i_read, d_read);
        serve_read(g, 2, 1'b0, 0);

        // dcache 8-beat writeback stalled on beats 3 and 6, icache waiting
        d_address = 32'h0000_4080; d_burstcount = 4'd8; d_write = 1'b1;
        cyc();
        g = model_pick(1'b0, 1'b1);
        i_address = 32'h0000_5000; i_burstcount = 4'd4; i_read = 1'b1;
        serve_write(8, 0, 16'h0024);
        cyc();
        g = model_pick(i_read, d_read | d_write);
        serve_read(g, 4, 1'b0, 0);

        // dcache read held off by the memory for 5 cycles, icache waiting
        d_address = 32'h0000_6100; d_burstcount = 4'd4; d_read = 1'b1;
        cyc();
        g = model_pick(1'b0, 1'b1);
        i_address = 32'h0000_7000; i_burstcount = 4'd3; i_read = 1'b1;
        m_waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
            look();
            check("t4_m_read_hold", 64'(m_read), 64'(1));
            check("t4_addr_hold", 64'(m_address), 64'(d_address));
            check("t4_d_wait", 64'(d_waitrequest), 64'(1));
            check("t4_i_wait", 64'(i_waitrequest), 64'(1));
            cyc();
        end
        m_waitrequest = 1'b0;
        serve_read(g, 4, 1'b0, 0);
        g = model_pick(i_read, d_read | d_write);
        serve_read(g, 3, 1'b0, 0);

        // reset after beat 4 of an icache fill, then stray beats
        i_address = 32'h0000_8040; i_burstcount = 4'd8; i_read = 1'b1;
        cyc();
        g = model_pick(1'b1, 1'b0);
        look();
        check("t5_m_read", 64'(m_read), 64'(1));
        cyc();
        i_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1;
            m_readdata = {$urandom, $urandom};
            look();
            check("t5_beat_rdv", 64'(i_readdatavalid), 64'(1));
            cyc();
        end
        reset = 1'b1;
        look();
        check_reset_outputs("t5_midburst");
        cyc();
        reset = 1'b0;
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1;
            look();
            check("t5_stray_i_rdv", 64'(i_readdatavalid), 64'(0));
            check("t5_stray_d_rdv", 64'(d_readdatavalid), 64'(0));
            cyc();
        end
        m_readdatavalid = 1'b0;
        d_address = 32'h0000_9000; d_burstcount = 4'd3; d_read = 1'b1;
        cyc();
        g = model_pick(1'b0, 1'b1);
        serve_read(g, 3, 1'b0, 0);

        // d_read and d_write together with burstcount 0
        d_address = 32'h0000_A000; d_burstcount = 4'd0; d_read = 1'b1; d_write = 1'b1;
        cyc();
        g = model_pick(1'b0, 1'b1);
        serve_write(0, 0, 16'h0000);
        cyc();
        g = model_pick(i_read, d_read | d_write);
        check("t6_read_after_write", 64'(g), 64'(1));
        serve_read(1'b1, 0, 1'b0, 0);

        // randomized traffic with memory stalls and gaps
        in_idle = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (!i_read && !d_read && !d_write) begin
                kind = int'($urandom_range(5));
                i_address = {$urandom} & 32'hFFFF_FFC0;
                d_address = {$urandom} & 32'hFFFF_FFC0;
                i_burstcount = BC_W'($urandom_range(8));
                d_burstcount = BC_W'($urandom_range(8));
                i_read  = (kind == 0) || (kind == 3) || (kind == 4);
                d_read  = (kind == 1) || (kind == 3) || (kind == 5);
                d_write = (kind == 2) || (kind == 4) || (kind == 5);
            end
            if (in_idle) cyc();
            g = model_pick(i_read, d_read | d_write);
            was_write = g && d_write;
            if (!g)
                serve_read(1'b0, int'(i_burstcount), 1'b0, 30);
            else if (d_write)
                serve_write(int'(d_burstcount), 30, 16'h0000);
            else
                serve_read(1'b1, int'(d_burstcount), 1'b0, 30);
            in_idle = was_write || !(i_read || d_read || d_write);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule

// File: doc/cache_memory_arbiter.md
Name: cache_memory_arbiter

Overview:
- Shares the single 64-bit Avalon-MM burst master between two requesters:
  - the instruction-cache miss engine (read-only line fills);
  - the data-cache miss/writeback engine (line fills and line writebacks).
- Grants whole bursts, never interleaves beats, and routes returning read beats to the owner only.
- Sits between both cache memory engines and the system interconnect.

Parameters:
- ADDR_W, 32, address width on all three interfaces.
- DATA_W, 64, beat width on all three interfaces.
- BC_W, 4, burstcount width; a full 64-byte line is 8 beats.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_address  in  ADDR_W  icache burst start address
- i_read  in  1  icache read request, held until accepted
- i_burstcount  in  BC_W  icache beats requested
- i_waitrequest  out  1  icache command stall
- i_readdata  out  DATA_W  read beat to icache
- i_readdatavalid  out  1  icache beat strobe
- d_address  in  ADDR_W  dcache burst start address
- d_read  in  1  dcache read request
- d_write  in  1  dcache write request, held for every beat
- d_writedata  in  DATA_W  dcache write beat
- d_burstcount  in  BC_W  dcache beats
- d_waitrequest  out  1  dcache command/beat stall
- d_readdata  out  DATA_W  read beat to dcache
- d_readdatavalid  out  1  dcache beat strobe
- m_address, m_read, m_write, m_writedata, m_burstcount  out  ADDR_W/1/1/DATA_W/BC_W  memory master command
- m_readdata, m_readdatavalid, m_waitrequest  in  DATA_W/1/1  memory master response

Behaviour:
- Clocking: one clock domain (clock); reset is asynchronous, active-high.
- States: IDLE, I_CMD, I_DATA, D_RCMD, D_RDATA, D_WR. State, beat counter, last_grant and the latched burst length are registers; all outputs are combinational from state and inputs.
- Reset values:
  - state=IDLE, beat counter=0, last_grant=D (so the icache wins the first tie);
  - m_read=0, m_write=0, i_waitrequest=1, d_waitrequest=1, both readdatavalid=0.
- IDLE arbitration:
  - i request = i_read; d request = d_read|d_write.
  - One request pending: grant it. Both pending: round-robin against last_grant.
  - Grant is registered, giving 1 cycle latency from request to m_read/m_write.
  - Entry target is I_CMD, D_RCMD or D_WR. last_grant is updated on grant.
  - On entry, the burst length is latched from the requester's burstcount; burstcount 0 is treated as 1.
- I_CMD / D_RCMD:
  - The owner's address, read and burstcount drive m_*; the owner's waitrequest equals m_waitrequest.
  - When read & !m_waitrequest, go to I_DATA / D_RDATA and clear the beat counter.
- I_DATA / D_RDATA:
  - Each m_readdatavalid drives the owner's readdata/readdatavalid and increments the counter.
  - When the counter reaches the latched length (last beat), return to IDLE in the next cycle. The last-beat cycle is also the IDLE decision point: a new grant may be registered in the same edge.
- D_WR:
  - Passes address, write, writedata and burstcount through.
  - The counter increments on each write & !m_waitrequest; after the final beat is accepted, go to IDLE.
- Non-owner handling:
  - The non-owner sees waitrequest=1 and readdatavalid=0 at all times.
  - m_readdatavalid while in IDLE or a CMD state is dropped (stale beats after a mid-burst reset).
- Simultaneous d_read and d_write: write wins (protocol error, counted as legal). The d_read request stays pending.
- Owner deasserting its request in a CMD state: the arbiter stays in the CMD state; master requests must be held until accepted.
- Reset mid-burst: immediate return to IDLE, counter cleared, m_read/m_write=0. Late beats are discarded as above.
- Counter is BC_W bits wide, with no wrap inside a legal burst (max 15 beats).

Optional Feature:
- Macro CACHE_ARB_IFETCH_PRIO_EN.
- Defined: fixed priority; the icache always wins a tie in IDLE and last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package cache_arb_pkg holds:
  - state encoding localparams (3-bit);
  - grant IDs GNT_I=0, GNT_D=1;
  - default beat count LINE_BEATS=8.
- Sub-module cache_arb_beat_counter:
  - loadable length, increment enable, clear, and a last-beat flag;
  - shared by the read-data and write paths.

Test Plan:
- icache-only 8-beat read at 0x0000_1040, m_waitrequest low:
  - m_read is seen 1 cycle after i_read, m_burstcount=8;
  - all 8 beats appear on i_readdatavalid and none on d_readdatavalid;
  - state returns to IDLE after beat 8.
- i_read and d_read asserted in the same cycle, three times back-to-back:
  - grants alternate I, D, I;
  - with CACHE_ARB_IFETCH_PRIO_EN defined, grants are I, I, I while i_read is re-asserted.
- dcache 8-beat write with m_waitrequest high on beats 3 and 6:
  - exactly 8 accepted beats with writedata order preserved;
  - d_waitrequest mirrors m_waitrequest;
  - i_waitrequest=1 throughout.
- dcache read with m_waitrequest held high for 5 cycles:
  - m_read and m_address are stable for all 5 cycles;
  - a concurrent i_read is not granted until the dcache burst completes.
- Reset asserted after beat 4 of an icache read, then 4 stray beats arrive:
  - outputs return to reset values immediately;
  - the stray beats produce no readdatavalid on either side;
  - a following d_read is granted normally.
- d_read and d_write asserted together with burstcount 0:
  - a single-beat write is issued and completes;
  - the d_read is then granted as a separate burst.
